ipml_prefetch_fifo_v2_0: RTL

//  Single-clock first-word-fall-through FIFO: inferred RAM with 1-cycle read latency,

---
 rtl/ipml_prefetch_fifo_v2_0.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/ipml_prefetch_fifo_v2_0.sv
// Purpose : single-clock FWFT FIFO; inferred RAM (1-cycle read) feeding a 2-entry output skid.
// Latency : a word pushed into an empty FIFO at edge T is presented (rd_vld=1) after edge T+2.
// Backpr. : wr_vld drops when the RAM holds DEPTH words; skid absorbs the read pipeline, 1 word/cycle.
//
// Ports:
//   clk, rst_n (async, active-low), flush (sync clear, active-high)
//   wr_data/wr_en/wr_vld   : write side, push = wr_en & wr_vld
//   rd_data/rd_en/rd_vld   : read side, pop = rd_en & rd_vld, rd_data valid while rd_vld=1
//   level                  : words held (RAM + in-flight read + skid), 0..DEPTH+2
//   almost_full/almost_empty : registered threshold flags on level
// Optional feature macro IPML_PREFETCH_FIFO_ERR_FLAG_EN adds sticky overflow/underflow outputs.
module ipml_prefetch_fifo_v2_0 #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned AFULL_TH  = 1020,
  parameter int unsigned AEMPTY_TH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  output logic              wr_vld,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_en,
  output logic              rd_vld,
  output logic [ADDR_W+1:0] level,
  output logic              almost_full,
  output logic              almost_empty
`ifdef IPML_PREFETCH_FIFO_ERR_FLAG_EN
  ,
  output logic              overflow,
  output logic              underflow
`endif
);

  localparam int unsigned       DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   RAM_FULL = {1'b1, {ADDR_W{1'b0}}};

  // Storage
  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [DATA_W-1:0] ram_dat_q;

  // Pointers and counts
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   ram_cnt_q, ram_cnt_d;
  logic              inflight_q, inflight_d;

  // Output skid: entry 0 is the head presented on rd_data
  logic [DATA_W-1:0] skid0_q, skid0_d;
  logic [DATA_W-1:0] skid1_q, skid1_d;
  logic [1:0]        skid_cnt_q, skid_cnt_d;

  logic [ADDR_W+1:0] level_q, level_d;
  logic              afull_q, afull_d;
  logic              aempty_q, aempty_d;

  logic              push, pop, issue;
  logic [1:0]        occ;

  assign wr_vld       = (ram_cnt_q != RAM_FULL);
  assign rd_vld       = (skid_cnt_q != 2'd0);
  assign rd_data      = skid0_q;
  assign level        = level_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;

  // Flush discards any request made in the same cycle.
  assign push = wr_en & wr_vld & ~flush;
  assign pop  = rd_en & rd_vld & ~flush;

  // Skid slots already claimed after this cycle's pop. skid_cnt + inflight never
  // exceeds 2, so a read is issued only when its data is guaranteed a slot.
  assign occ   = skid_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
  assign issue = (ram_cnt_q != '0) && (occ < 2'd2) && !flush;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ram_cnt_d  = ram_cnt_q;
    inflight_d = inflight_q;
    level_d    = level_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      ram_cnt_d  = '0;
      inflight_d = 1'b0;
      level_d    = '0;
    end else begin
      if (push)  wr_ptr_d = wr_ptr_q + 1'b1;
      if (issue) rd_ptr_d = rd_ptr_q + 1'b1;
      ram_cnt_d  = ram_cnt_q + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, issue};
      inflight_d = issue;
      level_d    = level_q + {{(ADDR_W+1){1'b0}}, push} - {{(ADDR_W+1){1'b0}}, pop};
    end
    afull_d  = (32'(level_d) >= AFULL_TH);
    aempty_d = (32'(level_d) <= AEMPTY_TH);
  end

  // Skid update: pop shifts entry 1 to the head, a landing RAM word fills the
  // first free slot after the shift.
  always_comb begin
    skid0_d    = skid0_q;
    skid1_d    = skid1_q;
    skid_cnt_d = skid_cnt_q;
    if (flush) begin
      skid0_d    = '0;
      skid1_d    = '0;
      skid_cnt_d = 2'd0;
    end else begin
      case ({pop, inflight_q})
        2'b01: begin
          if (skid_cnt_q == 2'd0) skid0_d = ram_dat_q;
          else                    skid1_d = ram_dat_q;
          skid_cnt_d = skid_cnt_q + 2'd1;
        end
        2'b10: begin
          skid0_d    = skid1_q;
          skid_cnt_d = skid_cnt_q - 2'd1;
        end
        2'b11: begin
          if (skid_cnt_q == 2'd1) begin
            skid0_d = ram_dat_q;
          end else begin
            skid0_d = skid1_q;
            skid1_d = ram_dat_q;
          end
        end
        default: ;
      endcase
    end
  end

  // RAM array and its read register carry no reset so they map onto block RAM.
  // Stale contents are unreachable because the pointers and counts are reset.
  always_ff @(posedge clk) begin
    if (push)  mem[wr_ptr_q] <= wr_data;
    if (issue) ram_dat_q     <= mem[rd_ptr_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= 1'b0;
      skid0_q    <= '0;
      skid1_q    <= '0;
      skid_cnt_q <= 2'd0;
      level_q    <= '0;
      afull_q    <= 1'b0;
      aempty_q   <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= inflight_d;
      skid0_q    <= skid0_d;
      skid1_q    <= skid1_d;
      skid_cnt_q <= skid_cnt_d;
      level_q    <= level_d;
      afull_q    <= afull_d;
      aempty_q   <= aempty_d;
    end
  end

`ifdef IPML_PREFETCH_FIFO_ERR_FLAG_EN
  logic overflow_q, underflow_q;

  // Sticky error flags; flush clears them with the rest of the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (flush) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_en && !wr_vld) overflow_q  <= 1'b1;
      if (rd_en && !rd_vld) underflow_q <= 1'b1;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule
